// File: rtl/riscv_cache_pkg.sv
// Purpose: shared widths, refill FSM state type, cache line layout and address helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_cache_pkg;

    // Address layout: A[15:8] tag, A[7:4] index, A[3:2] word, A[1:0] byte
    localparam int ADDR_WIDTH     = 16;
    localparam int DATA_WIDTH     = 32;
    localparam int TAG_WIDTH      = 8;
    localparam int INDEX_WIDTH    = 4;
    localparam int WORDS_PER_LINE = 4;
    localparam int BEAT_WIDTH     = 2;
    localparam int LINE_WIDTH     = 1 + TAG_WIDTH + WORDS_PER_LINE * DATA_WIDTH;

    localparam int WORD_LSB       = 2;
    localparam int INDEX_LSB      = 4;
    localparam int TAG_LSB        = 8;

    // Clears the word and byte offset, leaving the line base address
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(16'h000F);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } refill_state_e;

    // Packed so the flattened layout is {valid, tag, w3, w2, w1, w0}
    typedef struct packed {
        logic                                       valid;
        logic [TAG_WIDTH-1:0]                       tag;
        logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]  word;
    } cache_line_t;

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return TAG_WIDTH'(a >> TAG_LSB);
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return INDEX_WIDTH'(a >> INDEX_LSB);
    endfunction

    function automatic logic [BEAT_WIDTH-1:0] addr_word(input logic [ADDR_WIDTH-1:0] a);
        return BEAT_WIDTH'(a >> WORD_LSB);
    endfunction

    // Word-aligned address of one beat within the line containing a
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [BEAT_WIDTH-1:0] beat);
        return (a & LINE_MASK) | {{(ADDR_WIDTH-BEAT_WIDTH-WORD_LSB){1'b0}}, beat, 2'b00};
    endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Purpose: holds the words of a line being refilled, written one beat at a time.
// Latency: write visible on words the cycle after we.
// Backpressure: none; accepts a write every cycle.
module refill_line_buf
    import riscv_cache_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      we,
    input  logic [BEAT_WIDTH-1:0]                     widx,
    input  logic [DATA_WIDTH-1:0]                     wdata,
    output logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] words
);

    // Reset clears the whole buffer so an aborted fill leaves nothing behind
    always_ff @(posedge clk) begin
        if (rst) begin
            words <= '0;
        end else if (we) begin
            words[widx] <= wdata;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Purpose: fetches a missing 4-word line over req/ack and writes it into the cache (CACHE_REFILL_CWF_EN selects critical-word-first).
// Latency: fill_we one cycle after the 4th mem_ack; zero-wait miss at cycle 0 fills at cycle 5.
// Backpressure: holds mem_req/mem_addr until mem_ack; stalls the pipeline for the whole refill.
module cache_refill_ctrl
    import riscv_cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_valid,
    input  logic [ADDR_WIDTH-1:0]  miss_addr,
    output logic                   stall,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   fill_we,
    output logic [INDEX_WIDTH-1:0] fill_index,
    output logic [LINE_WIDTH-1:0]  fill_line,
    output logic [DATA_WIDTH-1:0]  fill_word,
    output logic                   fill_word_valid
);

    refill_state_e                             state;
    logic [ADDR_WIDTH-1:0]                     addr_q;
    logic [BEAT_WIDTH-1:0]                     beat;
    logic [BEAT_WIDTH-1:0]                     beat_inc;
    logic [BEAT_WIDTH-1:0]                     acks;
    logic [BEAT_WIDTH-1:0]                     start_beat;
    logic                                      buf_we;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] buf_words;
    cache_line_t                               line_next;
    cache_line_t                               fill_line_q;

    // Critical word first starts at the missing word and wraps; otherwise start at word 0
`ifdef CACHE_REFILL_CWF_EN
    assign start_beat = addr_word(miss_addr);
`else
    assign start_beat = '0;
`endif

    assign beat_inc  = beat + 2'd1;
    assign buf_we    = (state == ST_FETCH) && mem_ack;
    assign fill_line = fill_line_q;

    // The pipeline only sees the miss level while idle; any busy state holds it
    assign stall = (state == ST_IDLE) ? miss_valid : 1'b1;

    refill_line_buf u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .widx  (beat),
        .wdata (mem_rdata),
        .words (buf_words)
    );

    // Complete line as it will look once the current beat lands, so the last ack can register it directly
    always_comb begin
        line_next            = '0;
        line_next.valid      = 1'b1;
        line_next.tag        = addr_tag(addr_q);
        line_next.word       = buf_words;
        line_next.word[beat] = mem_rdata;
    end

    // Refill FSM: IDLE -> FETCH (4 beats) -> FILL -> IDLE, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            addr_q          <= '0;
            beat            <= '0;
            acks            <= '0;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            fill_we         <= 1'b0;
            fill_index      <= '0;
            fill_line_q     <= '0;
            fill_word       <= '0;
            fill_word_valid <= 1'b0;
        end else begin
            fill_we         <= 1'b0;
            fill_word_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (miss_valid) begin
                        addr_q   <= miss_addr;
                        beat     <= start_beat;
                        acks     <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= beat_addr(miss_addr, start_beat);
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        beat <= beat_inc;
                        acks <= acks + 2'd1;
`ifdef CACHE_REFILL_CWF_EN
                        // First beat is the requested word: hand it to the pipeline early
                        if (acks == 2'd0) begin
                            fill_word       <= mem_rdata;
                            fill_word_valid <= 1'b1;
                        end
`endif
                        if (acks == 2'd3) begin
                            mem_req     <= 1'b0;
                            fill_we     <= 1'b1;
                            fill_index  <= addr_index(addr_q);
                            fill_line_q <= line_next;
`ifndef CACHE_REFILL_CWF_EN
                            fill_word       <= line_next.word[addr_word(addr_q)];
                            fill_word_valid <= 1'b1;
`endif
                            state       <= ST_FILL;
                        end else begin
                            mem_addr <= beat_addr(addr_q, beat_inc);
                        end
                    end
                end
                ST_FILL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
